// File: rtl/fetch_sequencer.sv
// Instruction-fetch and control-flow sequencer: drives the ROM address from the PC,
// registers the instruction word and steers the PC load for jumps, reset and halt.
module fetch_sequencer #(
  parameter int unsigned     AW        = 4,
  parameter int unsigned     OPW       = 4,
  parameter logic [AW-1:0]   RESET_VEC = '0,
  parameter logic [OPW-1:0]  OP_JMP    = 4'hC,
  parameter logic [OPW-1:0]  OP_JZ     = 4'hD,
  parameter logic [OPW-1:0]  OP_HLT    = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     pc,
  input  logic              zf,
  output logic [AW-1:0]     rom_addr,
  input  logic [OPW+AW-1:0] rom_data,
  output logic              jmp,
  output logic [AW-1:0]     jmp_addr,
  output logic [OPW-1:0]    op,
  output logic [AW-1:0]     imm,
  output logic [AW-1:0]     ir_pc,
  output logic              exec_valid,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [OPW+AW-1:0]  ir;
  logic               ir_valid;
  logic               is_ctrl;

  assign rom_addr = pc;
  assign op       = ir[OPW+AW-1:AW];
  assign imm      = ir[AW-1:0];
  assign is_ctrl  = (op == OP_JMP) || (op == OP_JZ) || (op == OP_HLT);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (ir_valid && op == OP_HLT) state_nxt = S_HALT;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    jmp        = 1'b0;
    jmp_addr   = imm;
    exec_valid = 1'b0;
    halted     = 1'b0;
    case (state)
      S_IDLE: begin
        jmp      = 1'b1;
        jmp_addr = RESET_VEC;
      end
      S_RUN: begin
        if (ir_valid) begin
          if (op == OP_JMP) begin
            jmp = 1'b1;
          end else if (op == OP_JZ) begin
            jmp = zf;
          end else if (op == OP_HLT) begin
            jmp      = 1'b1;
            jmp_addr = ir_pc;
          end
          exec_valid = ~is_ctrl;
        end
      end
      S_HALT: begin
        jmp      = 1'b1;
        jmp_addr = ir_pc;
        halted   = 1'b1;
      end
      default: begin
        jmp      = 1'b1;
        jmp_addr = RESET_VEC;
      end
    endcase
  end

  // The IR also holds on the RUN->HALT edge so ir_pc keeps the HALT's own address.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else if (state == S_IDLE || (state == S_RUN && state_nxt == S_RUN)) begin
      ir       <= rom_data;
      ir_pc    <= pc;
      ir_valid <= ~jmp;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: external PC and ROM models, a cycle table for
// reset/run/halt, a scoreboard of executed instructions, and multi-cycle jump cases.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start1 = 1'b0;
  logic       zf = 1'b0;

  logic [3:0] pc, rom_addr, jmp_addr, op, imm, ir_pc;
  logic [7:0] rom_data;
  logic       jmp, exec_valid, halted;
  logic [7:0] rom [16];

  logic [3:0] pc1, rom_addr1, jmp_addr1, op1, imm1, ir_pc1;
  logic [7:0] rom_data1;
  logic       jmp1, exec_valid1, halted1;
  logic [7:0] rom1 [16];

  int total = 0;
  int bad = 0;
  logic [11:0] sb [$];

  always #5 clk = ~clk;

  fetch_sequencer #(.AW(4), .OPW(4), .RESET_VEC(4'd0)) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .zf(zf),
    .rom_addr(rom_addr), .rom_data(rom_data), .jmp(jmp), .jmp_addr(jmp_addr),
    .op(op), .imm(imm), .ir_pc(ir_pc), .exec_valid(exec_valid), .halted(halted)
  );

  fetch_sequencer #(.AW(4), .OPW(4), .RESET_VEC(4'd15)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pc(pc1), .zf(1'b0),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .jmp(jmp1), .jmp_addr(jmp_addr1),
    .op(op1), .imm(imm1), .ir_pc(ir_pc1), .exec_valid(exec_valid1), .halted(halted1)
  );

  // Program counters without reset or enable, as the real PC behaves.
  assign rom_data  = rom[rom_addr];
  assign rom_data1 = rom1[rom_addr1];
  always_ff @(posedge clk) pc  <= jmp  ? jmp_addr  : pc  + 4'd1;
  always_ff @(posedge clk) pc1 <= jmp1 ? jmp_addr1 : pc1 + 4'd1;

  typedef struct {
    logic       rst;
    logic       start;
    logic       exp_jmp;
    logic [3:0] exp_jaddr;
    logic       exp_ev;
    logic       exp_halt;
    logic       chk_pc;
    logic [3:0] exp_pc;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic j, logic [3:0] ja,
                              logic ev, logic h, logic cp, logic [3:0] p);
    vec_t v;
    v.rst = r; v.start = s; v.exp_jmp = j; v.exp_jaddr = ja;
    v.exp_ev = ev; v.exp_halt = h; v.chk_pc = cp; v.exp_pc = p;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Advance one cycle, then retire any instruction the DUT reports as executing.
  task automatic step();
    logic [11:0] e;
    @(posedge clk);
    #1;
    if (exec_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got %0h want none", {op, imm, ir_pc});
      end else begin
        e = sb.pop_front();
        chk("sb_exec", 32'({op, imm, ir_pc}), 32'(e));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  vec_t tbl [24];
  int   jcnt;

  initial begin
    clear_rom();
    for (int i = 0; i < 16; i++) rom1[i] = 8'h00;

    // Reset, linear run, halt with start ignored, reset recovery.
    rom[0] = 8'h31; rom[1] = 8'h42; rom[2] = 8'h53; rom[3] = 8'hF0;
    tbl[0] = mk(1, 0, 1, 4'd0, 0, 0, 0, 4'd0);
    tbl[1] = mk(1, 0, 1, 4'd0, 0, 0, 1, 4'd0);
    for (int i = 2; i < 5; i++) tbl[i] = mk(0, 0, 1, 4'd0, 0, 0, 1, 4'd0);
    tbl[5] = mk(0, 1, 0, 4'd0, 0, 0, 1, 4'd0);
    tbl[6] = mk(0, 0, 0, 4'd0, 1, 0, 1, 4'd1);
    tbl[7] = mk(0, 0, 0, 4'd0, 1, 0, 1, 4'd2);
    tbl[8] = mk(0, 0, 0, 4'd0, 1, 0, 1, 4'd3);
    tbl[9] = mk(0, 0, 1, 4'd3, 0, 0, 1, 4'd4);
    for (int i = 10; i < 22; i++) tbl[i] = mk(0, logic'(i % 2), 1, 4'd3, 0, 1, 1, 4'd3);
    tbl[22] = mk(1, 0, 1, 4'd0, 0, 0, 1, 4'd3);
    tbl[23] = mk(0, 0, 1, 4'd0, 0, 0, 1, 4'd0);

    sb.push_back(12'h310); sb.push_back(12'h421); sb.push_back(12'h532);
    for (int i = 0; i < 24; i++) begin
      rst   = tbl[i].rst;
      start = tbl[i].start;
      step();
      chk($sformatf("t%0d_jmp", i), 32'(jmp), 32'(tbl[i].exp_jmp));
      if (tbl[i].exp_jmp) chk($sformatf("t%0d_jaddr", i), 32'(jmp_addr), 32'(tbl[i].exp_jaddr));
      chk($sformatf("t%0d_ev", i), 32'(exec_valid), 32'(tbl[i].exp_ev));
      chk($sformatf("t%0d_halt", i), 32'(halted), 32'(tbl[i].exp_halt));
      if (tbl[i].chk_pc) chk($sformatf("t%0d_pc", i), 32'(pc), 32'(tbl[i].exp_pc));
    end
    start = 1'b0;

    // Taken jump: one load cycle, squashed 77 slot, target executes.
    clear_rom();
    rom[0] = 8'h31; rom[1] = 8'hC5; rom[2] = 8'h77; rom[5] = 8'h61; rom[6] = 8'hF0;
    sb.push_back(12'h310); sb.push_back(12'h615);
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    jcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (jmp && !halted && jmp_addr == 4'd5) jcnt++;
    end
    chk("jmp_pulse", 32'(jcnt), 32'd1);
    chk("jmp_halted", 32'(halted), 32'd1);
    chk("jmp_halt_addr", 32'(jmp_addr), 32'd6);

    // Conditional jump, not taken.
    clear_rom();
    rom[0] = 8'hD8; rom[1] = 8'h41; rom[2] = 8'hF0; rom[8] = 8'h39; rom[9] = 8'hF0;
    zf = 1'b0;
    sb.push_back(12'h411);
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("jz0_jmp", 32'(jmp), 32'd0);
    step();
    chk("jz0_irpc", 32'(ir_pc), 32'd1);
    for (int i = 0; i < 10 && !halted; i++) step();
    chk("jz0_halted", 32'(halted), 32'd1);

    // Conditional jump, taken.
    zf = 1'b1;
    sb.push_back(12'h398);
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("jz1_jmp", 32'(jmp), 32'd1);
    chk("jz1_jaddr", 32'(jmp_addr), 32'd8);
    step();
    step();
    chk("jz1_irpc", 32'(ir_pc), 32'd8);
    chk("jz1_ev", 32'(exec_valid), 32'd1);
    for (int i = 0; i < 10 && !halted; i++) step();
    chk("jz1_halted", 32'(halted), 32'd1);
    zf = 1'b0;

    // Wrap-around from RESET_VEC=15 on the second instance.
    rom1[15] = 8'h2F; rom1[0] = 8'h30;
    do_reset();
    chk("wrap_idle_pc", 32'(pc1), 32'd15);
    start1 = 1'b1; step(); start1 = 1'b0;
    jcnt = 0;
    if (jmp1) jcnt++;
    step();
    if (jmp1) jcnt++;
    chk("wrap_ev0", 32'(exec_valid1), 32'd1);
    chk("wrap_ir0", 32'({op1, imm1, ir_pc1}), 32'h2FF);
    step();
    if (jmp1) jcnt++;
    chk("wrap_ev1", 32'(exec_valid1), 32'd1);
    chk("wrap_ir1", 32'({op1, imm1, ir_pc1}), 32'h300);
    for (int i = 0; i < 4; i++) begin
      step();
      if (jmp1) jcnt++;
    end
    chk("wrap_nojmp", 32'(jcnt), 32'd0);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch and control-flow sequencer for the 4-bit CPU. It sits on the other side of the program counter.
- It reads the PC output value, presents it as the program-ROM address and registers the returned instruction word.
- It decodes control-flow opcodes and drives the PC load address and load control.
- The PC has no reset or enable, so this block also initialises the PC after reset and parks it on HALT.

Parameters:
- AW, 4: address width (PC, ROM address, jump target).
- OPW, 4: opcode width. Instruction word width is OPW+AW, with opcode in the MSBs and immediate in the LSBs.
- RESET_VEC, 0: address loaded into the PC while IDLE.
- OP_JMP, 4'hC: unconditional jump to the immediate.
- OP_JZ, 4'hD: jump to the immediate if zf=1.
- OP_HLT, 4'hF: halt.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE and begin execution (sampled in IDLE only).
- pc  in  AW  current PC value (the PC output).
- zf  in  1  ALU zero flag, sampled in the cycle a JZ is decoded.
- rom_addr  out  AW  program ROM address. Combinational, equal to pc.
- rom_data  in  OPW+AW  asynchronous ROM read data for rom_addr.
- jmp  out  1  PC load control. 1 means the PC loads jmp_addr at the next edge; 0 means the PC increments.
- jmp_addr  out  AW  PC load value.
- op  out  OPW  registered opcode (IR[OPW+AW-1:AW]).
- imm  out  AW  registered immediate (IR[AW-1:0]).
- ir_pc  out  AW  address the current IR was fetched from.
- exec_valid  out  1  IR holds a valid non-control instruction for the execute stage.
- halted  out  1  state is HALT.

Behaviour:
- Reset:
  - State becomes IDLE.
  - IR, ir_pc and ir_valid are cleared to 0, so op=0, imm=0, ir_pc=0 and exec_valid=0.
  - halted=0.
  - jmp=1 and jmp_addr=RESET_VEC, because they are combinational from IDLE.
  - rst overrides every other input, in any state, in the same edge.
- States and transitions:
  - IDLE → RUN when start=1; otherwise stay in IDLE.
  - RUN → HALT when ir_valid=1 and op=OP_HLT; otherwise stay in RUN.
  - HALT → HALT. HALT is left only via rst.
- IDLE:
  - jmp=1, jmp_addr=RESET_VEC, so the PC is forced to RESET_VEC every edge.
  - The IR captures with ir_valid=0.
  - On start, the transition edge still has jmp=1, so the first RUN cycle sees pc=RESET_VEC.
- RUN, every edge:
  - IR ← rom_data and ir_pc ← pc.
  - ir_valid ← ~jmp, i.e. the instruction fetched during a load cycle is squashed.
- RUN decode (combinational, from the IR, only when ir_valid=1):
  - OP_JMP: jmp=1, jmp_addr=imm.
  - OP_JZ with zf=1: jmp=1, jmp_addr=imm.
  - OP_JZ with zf=0: not taken, jmp=0.
  - OP_HLT: jmp=1, jmp_addr=ir_pc, and the state goes to HALT.
  - Any other opcode: jmp=0 and jmp_addr=imm (don't care).
- exec_valid = ir_valid AND op not in {OP_JMP, OP_JZ, OP_HLT} AND state==RUN.
- Latency:
  - Fetch to exec_valid is 1 cycle.
  - A taken jump costs 1 bubble: the PC holds the target 2 cycles after the jump was fetched, and the target instruction appears in the IR 3 cycles after.
- HALT:
  - jmp=1, jmp_addr=the HALT instruction's own address (ir_pc is frozen), so the PC is pinned.
  - halted=1, exec_valid=0.
  - The IR is frozen.
- Boundary cases:
  - PC wrap 15→0 needs no special handling; ir_pc records 0.
  - JMP to its own address loops forever with one bubble per iteration.
  - A control opcode in the squashed slot behind a taken jump is ignored.
  - start asserted in RUN or HALT is ignored.
  - rst during RUN or HALT returns to IDLE on that edge, with no partial jump.

Test Plan:
- Reset and initialisation:
  - rst=1 for 2 cycles, then rst=0 with start=0 for 3 cycles.
  - Required: jmp=1, jmp_addr=0, exec_valid=0 and halted=0 throughout; PC model reaches 0.
- Linear run:
  - ROM[0..2] = 31,42,53 hex; pulse start.
  - Required: starting the cycle after the PC is first seen at 0 in RUN, exec_valid=1 on consecutive cycles with op/imm = 3/1, 4/2, 5/3 and ir_pc = 0, 1, 2; jmp=0.
- Taken jump with flush:
  - ROM[1]=C5, ROM[2]=77, ROM[5]=61.
  - Required: jmp=1 with jmp_addr=5 for exactly 1 cycle; the 77 instruction never produces exec_valid; next valid instruction is op=6, imm=1, ir_pc=5.
- Conditional jump:
  - ROM[0]=D8; run once with zf=0 and once with zf=1.
  - zf=0 required: jmp stays 0 and ir_pc advances to 1.
  - zf=1 required: jmp=1 with jmp_addr=8, and next valid ir_pc=8.
- Halt and reset recovery:
  - ROM[3]=F0.
  - Required: halted=1 with jmp=1 and jmp_addr=3 held for 10+ cycles; PC stays 3; exec_valid=0; start has no effect.
  - Then rst=1 for 1 cycle. Required: IDLE, halted=0, jmp_addr=0.
- Wrap-around:
  - ROM[15]=2F, ROM[0]=30, started with RESET_VEC=15.
  - Required: valid ir_pc sequence 15 then 0, with no jmp asserted after IDLE.
